// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the boot-time program loader: FSM states,
// error codes, header field positions and memory-select encodings.
package mips_boot_pkg;

  typedef enum logic [2:0] {
    HDR     = 3'd0,
    PAYLOAD = 3'd1,
    CHECK   = 3'd2,
    DONE    = 3'd3,
    ERROR   = 3'd4
  } boot_state_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_CSUM  = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_EMPTY = 2'b11;

  localparam int HDR_TARGET_BIT = 31;
  localparam int HDR_END_BIT    = 30;
  localparam int HDR_BASE_LSB   = 16;
  localparam int HDR_COUNT_LSB  = 0;

  localparam logic SEL_IMEM = 1'b0;
  localparam logic SEL_DMEM = 1'b1;

endpackage

// File: rtl/imem_boot_loader.sv
// Streams header/payload/checksum segments into IMEM or DMEM through a single
// write port and holds the core idle until an end marker arrives.
module imem_boot_loader
  import mips_boot_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int IMEM_DEPTH = 512,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [7:0]        seg_count
);

  localparam logic [ADDR_W:0] IMEM_LIM = (ADDR_W+1)'(IMEM_DEPTH);
  localparam logic [ADDR_W:0] DMEM_LIM = (ADDR_W+1)'(DMEM_DEPTH);

  boot_state_e       state_q;
  logic              target_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] remain_q;
  logic [DATA_W-1:0] csum_q;
  logic              mem_we_q;
  logic              mem_sel_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              cpu_hold_q;
  logic              done_q;
  logic              error_q;
  logic [1:0]        err_code_q;
  logic [7:0]        seg_count_q;

  logic              hdr_target;
  logic              hdr_end;
  logic [ADDR_W-1:0] hdr_base;
  logic [ADDR_W-1:0] hdr_count;
  logic [ADDR_W:0]   hdr_span;
  logic [ADDR_W:0]   hdr_limit;
  logic              accept;

  // Header decode is evaluated every cycle; only consumed in HDR.
  assign hdr_target = in_data[HDR_TARGET_BIT];
  assign hdr_end    = in_data[HDR_END_BIT];
  assign hdr_base   = in_data[HDR_BASE_LSB +: ADDR_W];
  assign hdr_count  = in_data[HDR_COUNT_LSB +: ADDR_W];
  assign hdr_span   = {1'b0, hdr_base} + {1'b0, hdr_count};
  assign hdr_limit  = (hdr_target == SEL_DMEM) ? DMEM_LIM : IMEM_LIM;

  assign in_ready = rst && ((state_q == HDR) || (state_q == PAYLOAD) || (state_q == CHECK));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= HDR;
      target_q    <= SEL_IMEM;
      addr_q      <= '0;
      remain_q    <= '0;
      csum_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= SEL_IMEM;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ERR_NONE;
      seg_count_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        HDR: if (accept) begin
          if (hdr_end) begin
            state_q    <= DONE;
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
          end else if (hdr_count == '0) begin
            state_q    <= ERROR;
            error_q    <= 1'b1;
            err_code_q <= ERR_EMPTY;
          end else if (hdr_span > hdr_limit) begin
            state_q    <= ERROR;
            error_q    <= 1'b1;
            err_code_q <= ERR_RANGE;
          end else begin
            state_q  <= PAYLOAD;
            target_q <= hdr_target;
            addr_q   <= hdr_base;
            remain_q <= hdr_count;
            csum_q   <= '0;
          end
        end
        PAYLOAD: if (accept) begin
          mem_we_q    <= 1'b1;
          mem_sel_q   <= target_q;
          mem_addr_q  <= addr_q;
          mem_wdata_q <= in_data;
          addr_q      <= addr_q + ADDR_W'(1);
          csum_q      <= csum_q ^ in_data;
          remain_q    <= remain_q - ADDR_W'(1);
          if (remain_q == ADDR_W'(1)) state_q <= CHECK;
        end
        CHECK: if (accept) begin
          if (in_data == csum_q) begin
            state_q <= HDR;
            if (seg_count_q != 8'hFF) seg_count_q <= seg_count_q + 8'd1;
          end else begin
            state_q    <= ERROR;
            error_q    <= 1'b1;
            err_code_q <= ERR_CSUM;
          end
        end
        default: ;  // DONE and ERROR are terminal until reset
      endcase
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_sel   = mem_sel_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_code  = err_code_q;
  assign seg_count = seg_count_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: table of complete load streams with
// expected end state and last write, plus hand sequences for timing and reset.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic        mem_sel;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [7:0]  seg_count;

  imem_boot_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .err_code(err_code),
    .seg_count(seg_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sel;
    logic [9:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t wlog[$];

  always @(negedge clk) begin
    if (mem_we === 1'b1) wlog.push_back('{mem_sel, mem_addr, mem_wdata});
  end

  typedef struct {
    int          n;
    int          stall_at;
    logic        exp_done;
    logic        exp_err;
    logic [1:0]  exp_code;
    logic [7:0]  exp_seg;
    int          exp_nw;
    logic        exp_sel;
    logic [9:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NV = 8;
  vec_t        vt[NV];
  logic [31:0] wtab[NV][8];

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wlog.delete();
  endtask

  // Presents one word and waits (bounded) for it to be accepted.
  task automatic send(input logic [31:0] w);
    int t;
    t = 0;
    @(negedge clk);
    in_data = w;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin
      chk("send_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  initial begin
    vt[0] = '{4, -1, 1'b1, 1'b0, 2'b00, 8'd1, 1, 1'b0, 10'd1,    32'h0022_8020};
    wtab[0] = '{32'h0001_0001, 32'h0022_8020, 32'h0022_8020, 32'h4000_0000, 0, 0, 0, 0};
    vt[1] = '{5, 1, 1'b1, 1'b0, 2'b00, 8'd1, 2, 1'b1, 10'd2,     32'd9};
    wtab[1] = '{32'h8001_0002, 32'd10, 32'd9, 32'd3, 32'h4000_0000, 0, 0, 0};
    vt[2] = '{3, -1, 1'b0, 1'b1, 2'b01, 8'd0, 1, 1'b0, 10'd1,    32'h0022_8020};
    wtab[2] = '{32'h0001_0001, 32'h0022_8020, 32'h0000_0000, 0, 0, 0, 0, 0};
    vt[3] = '{1, -1, 1'b0, 1'b1, 2'b10, 8'd0, 0, 1'b0, 10'd0,    32'd0};
    wtab[3] = '{32'h01FF_0002, 0, 0, 0, 0, 0, 0, 0};
    vt[4] = '{4, -1, 1'b1, 1'b0, 2'b00, 8'd1, 1, 1'b1, 10'd1023, 32'hDEAD_BEEF};
    wtab[4] = '{32'h83FF_0001, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h4000_0000, 0, 0, 0, 0};
    vt[5] = '{1, -1, 1'b0, 1'b1, 2'b11, 8'd0, 0, 1'b0, 10'd0,    32'd0};
    wtab[5] = '{32'h0005_0000, 0, 0, 0, 0, 0, 0, 0};
    vt[6] = '{1, -1, 1'b1, 1'b0, 2'b00, 8'd0, 0, 1'b0, 10'd0,    32'd0};
    wtab[6] = '{32'h4000_0000, 0, 0, 0, 0, 0, 0, 0};
    vt[7] = '{7, -1, 1'b1, 1'b0, 2'b00, 8'd2, 2, 1'b1, 10'd5,    32'h22};
    wtab[7] = '{32'h0000_0001, 32'h11, 32'h11, 32'h8005_0001, 32'h22, 32'h22, 32'h4000_0000, 0};

    // Reset state, sampled while rst is still low
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_flags", {28'd0, done, error, err_code}, 32'd0);
    chk("rst_seg_count", {24'd0, seg_count}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    for (int v = 0; v < NV; v++) begin
      reset_dut();
      for (int w = 0; w < vt[v].n; w++) begin
        send(wtab[v][w]);
        if (w == vt[v].stall_at) repeat (3) @(negedge clk);
      end
      @(negedge clk);
      $display("vec %0d: done=%0b error=%0b err_code=%0d seg=%0d writes=%0d",
               v, done, error, err_code, seg_count, wlog.size());
      chk($sformatf("v%0d_done", v), {31'd0, done}, {31'd0, vt[v].exp_done});
      chk($sformatf("v%0d_error", v), {31'd0, error}, {31'd0, vt[v].exp_err});
      chk($sformatf("v%0d_err_code", v), {30'd0, err_code}, {30'd0, vt[v].exp_code});
      chk($sformatf("v%0d_seg_count", v), {24'd0, seg_count}, {24'd0, vt[v].exp_seg});
      chk($sformatf("v%0d_cpu_hold", v), {31'd0, cpu_hold}, {31'd0, ~vt[v].exp_done});
      chk($sformatf("v%0d_in_ready", v), {31'd0, in_ready}, 32'd0);
      chk($sformatf("v%0d_nwrites", v), wlog.size(), vt[v].exp_nw);
      if (wlog.size() > 0 && vt[v].exp_nw > 0) begin
        chk($sformatf("v%0d_last_sel", v), {31'd0, wlog[$].sel}, {31'd0, vt[v].exp_sel});
        chk($sformatf("v%0d_last_addr", v), {22'd0, wlog[$].addr}, {22'd0, vt[v].exp_addr});
        chk($sformatf("v%0d_last_data", v), wlog[$].data, vt[v].exp_data);
      end
      if (v == 1 && wlog.size() == 2)
        chk("v1_first_addr", {22'd0, wlog[0].addr}, 32'd1);
    end

    // Write appears exactly one cycle after the accepting edge, for one cycle
    reset_dut();
    send(32'h0001_0001);
    send(32'h0022_8020);
    $display("latency: we=%0b sel=%0b addr=%0d wdata=%h", mem_we, mem_sel, mem_addr, mem_wdata);
    chk("lat_we_high", {31'd0, mem_we}, 32'd1);
    chk("lat_addr", {22'd0, mem_addr}, 32'd1);
    chk("lat_wdata", mem_wdata, 32'h0022_8020);
    @(posedge clk);
    #1;
    chk("lat_we_low", {31'd0, mem_we}, 32'd0);
    send(32'h0022_8020);
    @(negedge clk);
    chk("lat_seg_count", {24'd0, seg_count}, 32'd1);
    chk("lat_back_in_hdr", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of a payload
    reset_dut();
    send(32'h0001_0003);
    send(32'hAAAA_5555);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    $display("midrst: we=%0b addr=%0d wdata=%h hold=%0b ready=%0b",
             mem_we, mem_addr, mem_wdata, cpu_hold, in_ready);
    chk("midrst_we", {31'd0, mem_we}, 32'd0);
    chk("midrst_addr", {22'd0, mem_addr}, 32'd0);
    chk("midrst_wdata", mem_wdata, 32'd0);
    chk("midrst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("midrst_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    wlog.delete();
    for (int w = 0; w < 4; w++) send(wtab[0][w]);
    @(negedge clk);
    chk("midrst_reload_done", {31'd0, done}, 32'd1);
    chk("midrst_reload_seg", {24'd0, seg_count}, 32'd1);
    chk("midrst_reload_nw", wlog.size(), 32'd1);
    if (wlog.size() == 1) chk("midrst_reload_addr", {22'd0, wlog[0].addr}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
